// File: rtl/sift_pkg.sv
// Types and sizing helpers shared by the SIFT octave stages (blur, DoG, extrema).
package sift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dog_state_t;

  function automatic int dog_width(input int pix_width);
    return pix_width + 1;
  endfunction

  // A 1x1 image still needs a one-bit address bus.
  function automatic int addr_width(input int dimension);
    int n;
    n = dimension * dimension;
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/dog_diff_lane.sv
// One DoG level pair: registered signed difference of two blurred pixels.
// With DOG_THRESH_EN defined, results whose magnitude is below THRESH are zeroed.
module dog_diff_lane
  import sift_pkg::*;
#(
  parameter  int PIX_WIDTH = 8,
  parameter  int THRESH    = 0,
  localparam int DOG_W     = dog_width(PIX_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 en_i,
  input  logic [PIX_WIDTH-1:0] a_i,
  input  logic [PIX_WIDTH-1:0] b_i,
  output logic [DOG_W-1:0]     d_o
);

  logic [DOG_W-1:0] diff_s;
  logic [DOG_W-1:0] d_d;
  logic [DOG_W-1:0] d_q;

`ifdef DOG_THRESH_EN
  logic [DOG_W-1:0] mag_s;

  // Sharper minus fuzzier, with small magnitudes suppressed.
  always_comb begin
    diff_s = {1'b0, a_i} - {1'b0, b_i};
    if (diff_s[DOG_W-1]) begin
      mag_s = ~diff_s + DOG_W'(1);
    end else begin
      mag_s = diff_s;
    end
    if (int'(mag_s) < THRESH) begin
      d_d = '0;
    end else begin
      d_d = diff_s;
    end
  end
`else
  logic unused_thresh_s;
  assign unused_thresh_s = (THRESH != 0);

  // Sharper minus fuzzier; the extra bit makes overflow impossible.
  always_comb begin
    diff_s = {1'b0, a_i} - {1'b0, b_i};
    d_d    = diff_s;
  end
`endif

  // Result register; holds while no pixel is at the tap.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      d_q <= '0;
    end else if (en_i) begin
      d_q <= d_d;
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/dog_pyramid.sv
// Difference-of-Gaussians engine for one octave: streams LEVELS blurred images from
// parallel BRAMs and writes LEVELS-1 signed DoG planes. Optional macro DOG_THRESH_EN.
module dog_pyramid
  import sift_pkg::*;
#(
  parameter  int DIMENSION    = 64,
  parameter  int PIX_WIDTH    = 8,
  parameter  int LEVELS       = 5,
  parameter  int READ_LATENCY = 2,
  parameter  int THRESH       = 0,
  localparam int ADDR_W       = addr_width(DIMENSION),
  localparam int DOG_W        = dog_width(PIX_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [LEVELS*PIX_WIDTH-1:0]   rd_pix,
  output logic                          busy,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [(LEVELS-1)*DOG_W-1:0]   wr_data,
  output logic                          done
);

  localparam int              N         = DIMENSION * DIMENSION;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  dog_state_t        state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic [READ_LATENCY-1:0] vld_q;
  logic [ADDR_W-1:0]       addr_pipe_q [READ_LATENCY];

  logic              tap_vld_s;
  logic [ADDR_W-1:0] tap_addr_s;
  logic              last_wr_s;

  assign tap_vld_s  = vld_q[READ_LATENCY-1];
  assign tap_addr_s = addr_pipe_q[READ_LATENCY-1];
  assign last_wr_s  = wr_en_q && (wr_addr_q == LAST_ADDR);

  // Pass sequencer: issues addresses, then waits for the last write to emerge.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          rd_addr_q <= '0;
          if (start) begin
            state_q <= READ;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (last_wr_s) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          rd_addr_q <= '0;
        end
        default: begin
          state_q   <= IDLE;
          rd_addr_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // Valid/address shadow of the BRAM read pipeline, plus the write-side strobe.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        addr_pipe_q[i] <= '0;
      end
    end else begin
      vld_q[0]       <= (state_q == READ);
      addr_pipe_q[0] <= rd_addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]       <= vld_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
      wr_en_q <= tap_vld_s;
      if (tap_vld_s) begin
        wr_addr_q <= tap_addr_s;
      end
    end
  end

  for (genvar k = 0; k < LEVELS - 1; k++) begin : g_lane
    dog_diff_lane #(
      .PIX_WIDTH (PIX_WIDTH),
      .THRESH    (THRESH)
    ) u_lane (
      .clk    (clk),
      .rst_in (rst_in),
      .en_i   (tap_vld_s),
      .a_i    (rd_pix[k*PIX_WIDTH +: PIX_WIDTH]),
      .b_i    (rd_pix[(k+1)*PIX_WIDTH +: PIX_WIDTH]),
      .d_o    (wr_data[k*DOG_W +: DOG_W])
    );
  end

  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;

endmodule
